// File: rtl/logicnet_stream_feeder.sv
// logicnet_stream_feeder: assembles feature beats for a fixed-latency LogicNet pipeline and buffers its results.
// Define LOGICNET_STREAM_FEEDER_PERF_EN to add the perf_vectors/perf_stall counters.
module logicnet_stream_feeder #(
    parameter int IN_WIDTH     = 32,
    parameter int FEAT_WIDTH   = 512,
    parameter int OUT_WIDTH    = 2,
    parameter int PIPE_LATENCY = 4,
    parameter int RES_DEPTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [FEAT_WIDTH-1:0] feat_out,
    input  logic [OUT_WIDTH-1:0]  cls_in,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  err
`ifdef LOGICNET_STREAM_FEEDER_PERF_EN
    ,
    output logic [31:0]           perf_vectors,
    output logic [31:0]           perf_stall
`endif
);
    localparam int BEATS = FEAT_WIDTH / IN_WIDTH;
    localparam int IW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int AW = RES_DEPTH > 1 ? $clog2(RES_DEPTH) : 1;
    localparam int CW = $clog2(RES_DEPTH + 1);
    localparam int PW = $clog2(PIPE_LATENCY + 2);
    typedef enum logic {COLLECT, LAUNCH} state_t;
    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic [FEAT_WIDTH-1:0] asm_q;
    logic [PIPE_LATENCY:0] vsr;
    logic [OUT_WIDTH-1:0] mem [RES_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [PW-1:0] inflight;
    logic accept, last_beat, done, bad, launch, push, pop;
    // vsr[k] set means the vector launched k cycles ago; vsr[PIPE_LATENCY] marks cls_in as its result
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= PIPE_LATENCY; i++) inflight = inflight + PW'(vsr[i]);
    end
    assign s_ready   = rst && state == COLLECT;
    assign accept    = s_valid && s_ready;
    assign last_beat = idx == IW'(BEATS - 1);
    assign done      = accept && last_beat && s_last;
    assign bad       = accept && (last_beat != s_last);
    assign launch    = state == LAUNCH && (32'(inflight) + 32'(count) < RES_DEPTH);
    assign push      = vsr[PIPE_LATENCY];
    assign pop       = m_valid && m_ready;
    assign m_valid   = count != '0;
    assign m_data    = m_valid ? mem[rd_ptr] : '0;
    always_comb begin
        state_nx = state;
        if (state == COLLECT) state_nx = done ? LAUNCH : COLLECT;
        else state_nx = launch ? COLLECT : LAUNCH;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= COLLECT;
            idx      <= '0;
            asm_q    <= '0;
            feat_out <= '0;
            vsr      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            vsr   <= {vsr[PIPE_LATENCY-1:0], launch};
            if (accept) begin
                asm_q[idx*IN_WIDTH +: IN_WIDTH] <= s_data;
                idx <= (last_beat || s_last) ? '0 : idx + 1'b1;
            end
            if (bad) err <= 1'b1;
            if (launch) feat_out <= asm_q;
            if (push) wr_ptr <= wr_ptr == AW'(RES_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr == AW'(RES_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cls_in;
    end
`ifdef LOGICNET_STREAM_FEEDER_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_vectors <= '0;
            perf_stall   <= '0;
        end else begin
            perf_vectors <= perf_vectors + 32'(launch);
            perf_stall   <= perf_stall + 32'(state == LAUNCH && !launch);
        end
    end
`endif
endmodule

// File: tb/tb_logicnet_stream_feeder.sv
// tb_logicnet_stream_feeder: directed checks of beat assembly, framing errors, credit backpressure and reset.
module tb_logicnet_stream_feeder;
    localparam int IN_WIDTH = 32;
    localparam int FEAT_WIDTH = 512;
    localparam int OUT_WIDTH = 2;
    localparam int PIPE_LATENCY = 4;
    localparam int RES_DEPTH = 8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [IN_WIDTH-1:0] s_data = '0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic s_ready;
    logic [FEAT_WIDTH-1:0] feat_out;
    logic [OUT_WIDTH-1:0] cls_in;
    logic [OUT_WIDTH-1:0] m_data;
    logic m_valid;
    logic m_ready = 1'b1;
    logic err;
`ifdef LOGICNET_STREAM_FEEDER_PERF_EN
    logic [31:0] perf_vectors, perf_stall;
`endif
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int lowcnt = 0;
    logic [OUT_WIDTH-1:0] res_q[$];
    int pop_cyc[$];
    logic [OUT_WIDTH-1:0] cpipe [PIPE_LATENCY];

    logicnet_stream_feeder dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .feat_out(feat_out), .cls_in(cls_in), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .err(err)
`ifdef LOGICNET_STREAM_FEEDER_PERF_EN
        , .perf_vectors(perf_vectors), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // classifier stand-in: registered pipeline, result = low two feature bits xor 2'b10
    always @(posedge clk) begin
        cpipe[0] <= feat_out[1:0] ^ 2'b10;
        for (int i = 1; i < PIPE_LATENCY; i++) cpipe[i] <= cpipe[i-1];
    end
    assign cls_in = cpipe[PIPE_LATENCY-1];

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            res_q.delete();
            pop_cyc.delete();
            lowcnt = 0;
        end else begin
            if (m_valid && m_ready) begin
                res_q.push_back(m_data);
                pop_cyc.push_back(cyc);
            end
            if (!s_ready) lowcnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        while (!s_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("s_ready_timeout", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic send_vec(input logic [31:0] base, input logic [31:0] step, input int last_at, input int nbeats);
        for (int k = 0; k < nbeats; k++) send_beat(base + k * step, k == last_at);
    endtask

    task automatic wait_mv(output int n);
        n = 0;
        while (!m_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_feat", feat_out == '0, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_err", err, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_s_ready", s_ready, 1);

        send_vec(0, 1, 15, 16);
        @(negedge clk);
        check("v1_feat_lo", feat_out[31:0], 0);
        check("v1_feat_hi", feat_out[511:480], 32'hF);
        wait_mv(n);
        check("v1_latency", n, PIPE_LATENCY + 1);
        check("v1_m_data", m_data, 2'b10);
        @(negedge clk);
        check("v1_single_pulse", m_valid, 0);

        send_vec(0, 1, 5, 6);
        check("early_last_err", err, 1);
        check("early_last_no_launch", s_ready, 1);
        send_vec(32'h101, 1, 15, 16);
        wait_mv(n);
        check("v2_m_data", m_data, 2'b11);
        check("v2_feat_lo", feat_out[31:0], 32'h101);
        check("v2_feat_hi", feat_out[511:480], 32'h110);
        check("v2_err_sticky", err, 1);
        @(negedge clk);
        check("v2_results", res_q.size(), 2);

        do_reset();
        send_vec(32'h200, 1, -1, 16);
        check("miss_last_err", err, 1);
        repeat (20) @(negedge clk);
        check("miss_last_no_result", res_q.size(), 0);
        check("miss_last_no_launch", feat_out[31:0], 0);

        do_reset();
        m_ready = 1'b0;
        fork
            for (int i = 0; i < 10; i++) send_vec(i, 256, 15, 16);
            begin
                repeat (250) @(negedge clk);
                check("bp_s_ready_low", s_ready, 0);
                check("bp_m_valid", m_valid, 1);
                check("bp_head", m_data, 2'b10);
                check("bp_no_pop", res_q.size(), 0);
                m_ready = 1'b1;
            end
        join
        n = 0;
        while (res_q.size() < 10 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        check("bp_count", res_q.size(), 10);
        for (int i = 0; i < 10 && i < res_q.size(); i++)
            check($sformatf("bp_order%0d", i), res_q[i], 2'(i) ^ 2'b10);
        if (pop_cyc.size() >= 8) check("bp_buffered8", pop_cyc[7] - pop_cyc[0], 7);
`ifdef LOGICNET_STREAM_FEEDER_PERF_EN
        check("perf_vectors", perf_vectors, 10);
        check("perf_stall", perf_stall, lowcnt - 10);
`endif

        do_reset();
        m_ready = 1'b0;
        send_vec(0, 1, 2, 3);
        send_vec(32'h300, 1, 15, 16);
        send_vec(32'h400, 1, 15, 16);
        send_vec(32'h500, 1, -1, 7);
        check("pre_rst_err", err, 1);
        s_valid = 1'b1;
        s_data = 32'h507;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_s_ready", s_ready, 0);
        check("mid_rst_feat", feat_out == '0, 1);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_m_data", m_data, 0);
        check("mid_rst_err", err, 0);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        m_ready = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (m_valid) n++;
        end
        check("post_rst_no_stale", n, 0);
        check("post_rst_no_result", res_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/logicnet_stream_feeder.md
Name: logicnet_stream_feeder

Overview:
- Streaming front/back end for the registered LogicNet classifier pipeline.
- Input side: accepts narrow feature beats over a valid/ready stream and assembles the FEAT_WIDTH-bit feature vector driven onto the classifier input. Tracks each launched vector through the fixed-latency, non-stallable classifier pipeline.
- Output side: captures each class result into a result FIFO, drained over a valid/ready stream. Credit-limits launches so no result is ever dropped.

Parameters:
- IN_WIDTH, 32, input beat width; FEAT_WIDTH must be an integer multiple of it.
- FEAT_WIDTH, 512, feature vector width (classifier input).
- OUT_WIDTH, 2, classifier result width.
- PIPE_LATENCY, 4, cycles from feat_out change to matching cls_in.
- RES_DEPTH, 8, result FIFO entries; must be >= 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- s_data  input  IN_WIDTH  feature beat.
- s_valid  input  1  beat valid.
- s_last  input  1  final beat of vector.
- s_ready  output  1  beat accepted when s_valid&s_ready.
- feat_out  output  FEAT_WIDTH  assembled vector to classifier input.
- cls_in  input  OUT_WIDTH  classifier output.
- m_data  output  OUT_WIDTH  result.
- m_valid  output  1  result valid.
- m_ready  input  1  result accepted when m_valid&m_ready.
- err  output  1  sticky framing error.

Behaviour:
- Reset (rst low, async): all outputs 0. Beat index 0, state COLLECT, in-flight tracker cleared, FIFO empty, err=0.
- BEATS = FEAT_WIDTH/IN_WIDTH (16 by default). Beat k writes assembly register bits [k*IN_WIDTH +: IN_WIDTH]; LSB first.
- State COLLECT:
  - s_ready=1.
  - Each accepted beat increments the index.
  - Accepting beat BEATS-1 with s_last=1 completes the vector: go to LAUNCH.
- Framing errors, both set err=1, discard the partial vector, reset the index to 0 and stay in COLLECT:
  - s_last=1 on beat index < BEATS-1.
  - s_last=0 on beat index BEATS-1.
- State LAUNCH:
  - s_ready=0.
  - Launch when inflight + fifo_count < RES_DEPTH. Write the assembly register to feat_out, push a 1 into the PIPE_LATENCY-deep valid shift register, return to COLLECT.
  - Launch can occur the cycle after the last beat at the earliest: max throughput is one vector per BEATS+1 cycles.
- feat_out holds its value between launches. The classifier samples every cycle, and only the tracked valid marks meaningful results.
- Valid shift register:
  - A bit pushed at launch cycle t (feat_out updated at edge t) exits at cycle t+PIPE_LATENCY.
  - On exit, cls_in is written into the FIFO that cycle.
  - inflight = popcount of the shift register.
- Result FIFO:
  - First-word-fall-through; m_valid = !empty; m_data = head.
  - Simultaneous push and pop on a non-empty FIFO: count is unchanged. Push when empty, with m_ready=1: entry appears next cycle, no bypass.
  - Overflow cannot occur because of the credit rule; verification asserts it.
- err: cleared only by reset. Error does not block further traffic.
- Reset mid-vector or mid-flight: everything is discarded, no result emitted.

Optional Feature:
- Macro: LOGICNET_STREAM_FEEDER_PERF_EN.
- Defined: adds outputs perf_vectors (32-bit count of launches) and perf_stall (32-bit count of cycles in LAUNCH without launching). Both wrap at 2^32 and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single vector: 16 beats 0x00000000..0x0000000F with s_last on beat 15 and m_ready=1. Expected:
  - feat_out[31:0]=0, feat_out[511:480]=0xF.
  - Classifier model cls_in=2'b10 returns m_data=2'b10 with one m_valid pulse, PIPE_LATENCY+1 cycles after launch.
- Early s_last on beat 5 -> err=1, no launch, index resets. Next clean 16-beat vector launches normally and err stays 1.
- Missing s_last on beat 15 -> err=1, vector discarded, m_valid never asserts for it.
- Backpressure, m_ready=0 with 10 vectors sent back-to-back -> exactly 8 results buffered, s_ready held 0 in LAUNCH, no overwrite. Release m_ready -> all 10 results emerge in order with no loss.
- Reset asserted mid-beat 7 and with 2 vectors in flight -> all outputs 0 immediately. No stale results after release.
- With LOGICNET_STREAM_FEEDER_PERF_EN defined, rerun the backpressure test -> perf_vectors=10 and perf_stall equals the number of stalled LAUNCH cycles counted by the bench.
